// File: rtl/conv_stream_loader.sv
// Serial-to-parallel operand loader and result drainer for the 2x2 systolic
// convolution core: 25 bytes in, one start pulse, four result bytes out.
module conv_stream_loader #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] i00, i01, i02, i03,
  output logic [7:0] i10, i11, i12, i13,
  output logic [7:0] i20, i21, i22, i23,
  output logic [7:0] i30, i31, i32, i33,
  output logic [7:0] f00, f01, f02,
  output logic [7:0] f10, f11, f12,
  output logic [7:0] f20, f21, f22,
  output logic       start,
  input  logic       done,
  input  logic [7:0] o00, o01, o10, o11,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [4:0]       k_q, k_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [15:0][7:0] i_q, i_d;
  logic [8:0][7:0]  f_q, f_d;
  logic [3:0][7:0]  r_q, r_d;
  logic [4:0]       fk_s;
  logic             err_s;

  assign fk_s = k_q - 5'd16;

  // Next-state, operand write and result capture decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    i_d     = i_q;
    f_d     = f_q;
    r_d     = r_q;
    err_s   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (k_q < 5'd16) begin
            i_d[k_q[3:0]] = in_data;
          end else begin
            f_d[fk_s[3:0]] = in_data;
          end
          if (k_q == 5'd24) begin
            k_d     = 5'd0;
            state_d = ST_START;
          end else begin
            k_d = k_q + 5'd1;
          end
        end else begin
          k_d = k_q;
        end
      end
      ST_START: begin
        tcnt_d  = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + 8'd1;
        // done takes priority over a coincident timeout
        if (done) begin
          r_d     = {o11, o10, o01, o00};
          idx_d   = 2'd0;
          state_d = ST_DRAIN;
        end else if (tcnt_q == TMO_LAST) begin
          err_s   = 1'b1;
          k_d     = 5'd0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, counters, operand and result registers
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      k_q     <= 5'd0;
      idx_q   <= 2'd0;
      tcnt_q  <= 8'd0;
      i_q     <= '0;
      f_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      i_q     <= i_d;
      f_q     <= f_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign start     = (state_q == ST_START);
  assign busy      = (state_q != ST_LOAD);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = r_q[idx_q];
  // err must land on the final WAIT cycle and be vetoed by a same-cycle done
  assign err       = err_s;

  assign {i03, i02, i01, i00} = i_q[3:0];
  assign {i13, i12, i11, i10} = i_q[7:4];
  assign {i23, i22, i21, i20} = i_q[11:8];
  assign {i33, i32, i31, i30} = i_q[15:12];
  assign {f02, f01, f00}      = f_q[2:0];
  assign {f12, f11, f10}      = f_q[5:3];
  assign {f22, f21, f20}      = f_q[8:6];

endmodule

// File: tb/tb_conv_stream_loader.sv
// Scoreboard bench for conv_stream_loader: directed operand streams, result
// queue checked by an independent output monitor.
module tb_conv_stream_loader;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] i00, i01, i02, i03, i10, i11, i12, i13;
  logic [7:0] i20, i21, i22, i23, i30, i31, i32, i33;
  logic [7:0] f00, f01, f02, f10, f11, f12, f20, f21, f22;
  logic       start;
  logic       done = 1'b0;
  logic [7:0] o00 = 8'd0, o01 = 8'd0, o10 = 8'd0, o11 = 8'd0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       err;

  conv_stream_loader #(.DONE_TIMEOUT(8)) dut (
    .clk_in(clk_in), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .i00(i00), .i01(i01), .i02(i02), .i03(i03), .i10(i10), .i11(i11), .i12(i12), .i13(i13),
    .i20(i20), .i21(i21), .i22(i22), .i23(i23), .i30(i30), .i31(i31), .i32(i32), .i33(i33),
    .f00(f00), .f01(f01), .f02(f02), .f10(f10), .f11(f11), .f12(f12),
    .f20(f20), .f21(f21), .f22(f22),
    .start(start), .done(done), .o00(o00), .o01(o01), .o10(o10), .o11(o11),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always #5 clk_in = ~clk_in;

  logic [199:0] ops_flat;
  assign ops_flat = {f22, f21, f20, f12, f11, f10, f02, f01, f00,
                     i33, i32, i31, i30, i23, i22, i21, i20,
                     i13, i12, i11, i10, i03, i02, i01, i00};

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitor: every accepted result is popped against the scoreboard
  always @(negedge clk_in) begin
    if (start) start_cnt++;
    if (err) err_cnt++;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected actual=%0h required=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        pop_cnt++;
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL out_data actual=%0h required=%0h", out_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bytes(input int base, input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      in_data  = 8'(base + k);
      in_valid = 1'b1;
      tick();
      if (gap && (k < n - 1)) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // Called in the START cycle: done is raised on the first WAIT cycle
  task automatic respond(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    tick();
    done = 1'b1;
    o00 = a; o01 = b; o10 = c; o11 = d;
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    tick();
    done = 1'b0;
    o00 = 8'd0; o01 = 8'd0; o10 = 8'd0; o11 = 8'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check(name, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_all_ops(input string name, input int base);
    for (int k = 0; k < 25; k++) begin
      check(name, {24'd0, ops_flat[k*8 +: 8]}, 32'(8'(base + k)));
    end
  endtask

  initial begin
    int s0, e0, p0;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int s0, e0, p0;
    // Test 1: reset values, then reset mid-stream
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    rst = 1'b1;
    tick();
    send_bytes(9, 10, 1'b0);
    check("partial_i00", {24'd0, i00}, 32'd9);
    rst = 1'b0;
    #1;
    check("midrst_ops", {31'd0, (ops_flat == 200'd0)}, 32'd1);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Test 2: full transaction, restarting at i00
    out_ready = 1'b1;
    s0 = start_cnt;
    send_bytes(1, 25, 1'b0);
    check("t2_start_cyc26", {31'd0, start}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_in_ready", {31'd0, in_ready}, 32'd0);
    check("t2_i00", {24'd0, i00}, 32'd1);
    check("t2_i33", {24'd0, i33}, 32'd16);
    check("t2_f00", {24'd0, f00}, 32'd17);
    check("t2_f22", {24'd0, f22}, 32'd25);
    respond(8'h11, 8'h22, 8'h33, 8'h44);
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);
    check("t2_ops_hold", {24'd0, f22}, 32'd25);
    wait_idle("t2_idle");
    check("t2_start_once", 32'(start_cnt - s0), 32'd1);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 3: in_valid toggling every cycle
    s0 = start_cnt;
    send_bytes(100, 25, 1'b1);
    check("t3_start", {31'd0, start}, 32'd1);
    check_all_ops("t3_ops", 100);
    respond(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    wait_idle("t3_idle");
    check("t3_start_once", 32'(start_cnt - s0), 32'd1);

    // Test 4: backpressure at idx=1
    p0 = pop_cnt;
    send_bytes(50, 25, 1'b0);
    respond(8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("t4_hold_data", {24'd0, out_data}, 32'h22);
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t4_idle");
    check("t4_pop_count", 32'(pop_cnt - p0), 32'd4);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // Test 5: timeout with done never asserted
    e0 = err_cnt;
    p0 = pop_cnt;
    send_bytes(30, 25, 1'b0);
    for (int w = 1; w <= 8; w++) begin
      tick();
      check("t5_err_timing", {31'd0, err}, (w == 8) ? 32'd1 : 32'd0);
      check("t5_no_out_valid", {31'd0, out_valid}, 32'd0);
    end
    tick();
    check("t5_back_to_load", {31'd0, in_ready}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_err_once", 32'(err_cnt - e0), 32'd1);
    check("t5_no_pop", 32'(pop_cnt - p0), 32'd0);

    // Test 5b: next load starts again at i00 after abort
    send_bytes(70, 25, 1'b0);
    check("t5b_i00", {24'd0, i00}, 32'd70);
    check("t5b_f22", {24'd0, f22}, 32'd94);

    // Test 6: done coinciding with the timeout cycle
    e0 = err_cnt;
    for (int w = 1; w <= 7; w++) tick();
    tick();
    done = 1'b1;
    o00 = 8'h55; o01 = 8'h66; o10 = 8'h77; o11 = 8'h88;
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    #1;
    check("t6_no_err", {31'd0, err}, 32'd0);
    tick();
    done = 1'b0;
    check("t6_drain", {31'd0, out_valid}, 32'd1);
    check("t6_first", {24'd0, out_data}, 32'h55);
    wait_idle("t6_idle");
    check("t6_err_count", 32'(err_cnt - e0), 32'd0);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
